// File: rtl/square_event_generator_pkg.sv
// Shared types and constants for the square event generator.
//   sq_state_e : 2-bit state encoding (NORMAL 00, COOLDOWN 01, INVINCIBLE 10, DRAIN 11)
//   hit_ev_t   : one bit per collision source, used for edge registers and events
//   DEF_*      : default frame counts and timer width
//   pend_inc   : saturating increment of the queued-heart count
package square_event_generator_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL     = 2'b00,
    ST_COOLDOWN   = 2'b01,
    ST_INVINCIBLE = 2'b10,
    ST_DRAIN      = 2'b11
  } sq_state_e;

  typedef struct packed {
    logic obstacle;
    logic heart;
    logic star;
  } hit_ev_t;

  localparam int DEF_INVINCIBLE_FRAMES    = 300;
  localparam int DEF_HURT_COOLDOWN_FRAMES = 60;
  localparam int DEF_TIMER_WIDTH          = 9;
  localparam logic [1:0] PENDING_MAX      = 2'd2;

  function automatic logic [1:0] pend_inc(input logic [1:0] p);
    return (p >= PENDING_MAX) ? PENDING_MAX : p + 2'd1;
  endfunction

endpackage

// File: rtl/square_event_generator_if.sv
// Collision-in / event-out bundle between the collision detector, the
// event generator and the square colour FSM.
//   master : drives PAUSE, FRAME_TICK, HIT_* ; observes the event outputs
//   slave  : the event generator side
interface square_event_generator_if #(
  parameter int TIMER_WIDTH = 9
);
  logic                   PAUSE;
  logic                   FRAME_TICK;
  logic                   HIT_OBSTACLE;
  logic                   HIT_HEART;
  logic                   HIT_STAR;
  logic                   HURT;
  logic                   RECOVER;
  logic                   INVINCIBLE_ENABLE;
  logic [TIMER_WIDTH-1:0] INVINCIBLE_LEFT;
  logic                   COOLDOWN_ACTIVE;

  modport master (
    output PAUSE, FRAME_TICK, HIT_OBSTACLE, HIT_HEART, HIT_STAR,
    input  HURT, RECOVER, INVINCIBLE_ENABLE, INVINCIBLE_LEFT, COOLDOWN_ACTIVE
  );

  modport slave (
    input  PAUSE, FRAME_TICK, HIT_OBSTACLE, HIT_HEART, HIT_STAR,
    output HURT, RECOVER, INVINCIBLE_ENABLE, INVINCIBLE_LEFT, COOLDOWN_ACTIVE
  );
endinterface

// File: rtl/square_event_generator_frame_down_counter.sv
// Frame down-counter with load, clear and saturation at zero.
//   CLK, RESET : clock, synchronous active-high reset
//   load       : load load_val (clear has priority)
//   clear      : force count to 0
//   tick       : decrement enable (caller gates with PAUSE/state)
//   count      : current value
//   zero       : count == 0
//   expire     : this tick takes count from 1 to 0
module frame_down_counter #(
  parameter int WIDTH = 9
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  input  logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             expire
);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge CLK) begin
    if (RESET)                     count <= '0;
    else if (clear)                count <= '0;
    else if (load)                 count <= load_val;
    else if (tick && count != '0)  count <= count - ONE;
  end

  assign zero   = (count == '0);
  assign expire = tick && (count == ONE);
endmodule

// File: rtl/square_event_generator.sv
// Converts collision levels into HURT / RECOVER pulses and an invincibility
// window, with a post-damage grace period and a queue of hearts picked up
// while invincible (replayed as RECOVER pulses once the window closes).
//   CLK, RESET : clock, synchronous active-high reset
//   bus        : slave side of square_event_generator_if
//                (PAUSE, FRAME_TICK, HIT_* in; HURT, RECOVER,
//                 INVINCIBLE_ENABLE, INVINCIBLE_LEFT, COOLDOWN_ACTIVE out)
module square_event_generator
  import square_event_generator_pkg::*;
#(
  parameter int INVINCIBLE_FRAMES    = DEF_INVINCIBLE_FRAMES,
  parameter int HURT_COOLDOWN_FRAMES = DEF_HURT_COOLDOWN_FRAMES,
  parameter int TIMER_WIDTH          = DEF_TIMER_WIDTH
) (
  input  logic                    CLK,
  input  logic                    RESET,
  square_event_generator_if.slave bus
);
  localparam logic [TIMER_WIDTH-1:0] INV_LOAD = TIMER_WIDTH'(INVINCIBLE_FRAMES);
  localparam logic [TIMER_WIDTH-1:0] CD_LOAD  = TIMER_WIDTH'(HURT_COOLDOWN_FRAMES);

  sq_state_e state_q, state_d;
  hit_ev_t   cur, prev_q, ev;
  logic      hurt_q, hurt_d, rec_q, rec_d;
  logic [1:0] pend_q, pend_d, pend_dec;
  logic      tick;

  logic                   inv_load, inv_clear, inv_tick, inv_zero, inv_expire;
  logic                   cd_load, cd_clear, cd_tick, cd_zero, cd_expire;
  logic [TIMER_WIDTH-1:0] inv_cnt, cd_cnt;

  assign cur  = '{obstacle: bus.HIT_OBSTACLE, heart: bus.HIT_HEART, star: bus.HIT_STAR};
  // Edge registers keep tracking while paused so a level held through a
  // pause does not fire when the pause lifts.
  assign ev   = bus.PAUSE ? hit_ev_t'('0) : hit_ev_t'(cur & ~prev_q);
  assign tick = bus.FRAME_TICK & ~bus.PAUSE;

  assign inv_tick = tick && (state_q == ST_INVINCIBLE);
  assign cd_tick  = tick && (state_q == ST_COOLDOWN || state_q == ST_DRAIN);

  frame_down_counter #(.WIDTH(TIMER_WIDTH)) u_inv_timer (
    .CLK(CLK), .RESET(RESET), .load(inv_load), .load_val(INV_LOAD),
    .clear(inv_clear), .tick(inv_tick), .count(inv_cnt),
    .zero(inv_zero), .expire(inv_expire)
  );

  frame_down_counter #(.WIDTH(TIMER_WIDTH)) u_cd_timer (
    .CLK(CLK), .RESET(RESET), .load(cd_load), .load_val(CD_LOAD),
    .clear(cd_clear), .tick(cd_tick), .count(cd_cnt),
    .zero(cd_zero), .expire(cd_expire)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_NORMAL;
      prev_q  <= '1;  // a level already high at reset release is not an edge
      hurt_q  <= 1'b0;
      rec_q   <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= cur;
      hurt_q  <= hurt_d;
      rec_q   <= rec_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hurt_d    = 1'b0;
    rec_d     = 1'b0;
    pend_d    = pend_q;
    pend_dec  = pend_q;
    inv_load  = 1'b0;
    inv_clear = 1'b0;
    cd_load   = 1'b0;
    cd_clear  = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        if (ev.star) begin
          state_d  = ST_INVINCIBLE;
          inv_load = 1'b1;
          rec_d    = ev.heart;
        end else if (ev.obstacle) begin
          // heart on the same edge cancels the damage pulse but the grace
          // period still starts
          state_d = ST_COOLDOWN;
          cd_load = 1'b1;
          hurt_d  = ~ev.heart;
        end else begin
          rec_d = ev.heart;
        end
      end
      ST_COOLDOWN: begin
        rec_d = ev.heart;
        if (ev.star) begin
          state_d  = ST_INVINCIBLE;
          inv_load = 1'b1;
          cd_clear = 1'b1;
        end else if (cd_expire || cd_zero) begin
          state_d = ST_NORMAL;
        end
      end
      ST_INVINCIBLE: begin
        if (ev.heart) pend_d = pend_inc(pend_q);
        if (ev.star) begin
          inv_load = 1'b1;
        end else if (inv_expire || inv_zero) begin
          inv_clear = 1'b1;
          cd_load   = 1'b1;
          state_d   = (pend_d != 2'd0) ? ST_DRAIN : ST_COOLDOWN;
        end
      end
      ST_DRAIN: begin
        if (ev.star) begin
          state_d  = ST_INVINCIBLE;
          inv_load = 1'b1;
          cd_clear = 1'b1;
          if (ev.heart) pend_d = pend_inc(pend_q);
        end else begin
          rec_d    = (pend_q != 2'd0);
          pend_dec = (pend_q != 2'd0) ? pend_q - 2'd1 : 2'd0;
          pend_d   = ev.heart ? pend_inc(pend_dec) : pend_dec;
          // cooldown timer keeps running into COOLDOWN
          if (pend_d == 2'd0) state_d = ST_COOLDOWN;
        end
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  assign bus.HURT              = hurt_q;
  assign bus.RECOVER           = rec_q;
  assign bus.INVINCIBLE_ENABLE = (state_q == ST_INVINCIBLE);
  assign bus.INVINCIBLE_LEFT   = inv_cnt;
  assign bus.COOLDOWN_ACTIVE   = (state_q == ST_COOLDOWN);
endmodule

// File: tb/tb_square_event_generator.sv
module tb_square_event_generator;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  int   rec_seen, hurt_seen;

  square_event_generator_if #(.TIMER_WIDTH(9)) bus ();

  square_event_generator #(
    .INVINCIBLE_FRAMES(300), .HURT_COOLDOWN_FRAMES(60), .TIMER_WIDTH(9)
  ) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       pause, tick, obs, heart, star;
    logic       hurt, rec, en, cd;
    logic [8:0] left;
  } vec_t;

  vec_t vecs[15];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic drive(input logic p, t, o, h, s);
    bus.PAUSE = p; bus.FRAME_TICK = t;
    bus.HIT_OBSTACLE = o; bus.HIT_HEART = h; bus.HIT_STAR = s;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    drive(0, 0, 0, 0, 0);
    step(); step();
    RESET = 1'b0;
    step();
  endtask

  // n frames: one tick cycle plus one idle cycle each, counting pulses seen
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      bus.FRAME_TICK = 1'b1; step();
      rec_seen += int'(bus.RECOVER); hurt_seen += int'(bus.HURT);
      bus.FRAME_TICK = 1'b0; step();
      rec_seen += int'(bus.RECOVER); hurt_seen += int'(bus.HURT);
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    // reset state
    step(); step();
    chk("reset_hurt", int'(bus.HURT), 0);
    chk("reset_rec",  int'(bus.RECOVER), 0);
    chk("reset_en",   int'(bus.INVINCIBLE_ENABLE), 0);
    chk("reset_left", int'(bus.INVINCIBLE_LEFT), 0);
    chk("reset_cd",   int'(bus.COOLDOWN_ACTIVE), 0);
    RESET = 1'b0;
    step();

    // ---- table: pause tick obs heart star | hurt rec en cd left
    vecs[0]  = '{0,0,0,0,0, 0,0,0,0,  0};
    vecs[1]  = '{0,0,0,1,0, 0,1,0,0,  0};  // heart edge
    vecs[2]  = '{0,0,0,1,0, 0,0,0,0,  0};  // heart held
    vecs[3]  = '{0,0,0,0,0, 0,0,0,0,  0};
    vecs[4]  = '{0,0,1,0,0, 1,0,0,1,  0};  // obstacle -> HURT, cooldown
    vecs[5]  = '{0,0,1,0,0, 0,0,0,1,  0};  // held
    vecs[6]  = '{0,0,0,0,0, 0,0,0,1,  0};
    vecs[7]  = '{0,0,1,0,0, 0,0,0,1,  0};  // ignored in cooldown
    vecs[8]  = '{0,0,0,1,0, 0,1,0,1,  0};  // heart in cooldown
    vecs[9]  = '{0,0,0,0,1, 0,0,1,0,300};  // star leaves cooldown
    vecs[10] = '{0,0,1,0,0, 0,0,1,0,300};  // obstacle ignored
    vecs[11] = '{0,0,0,1,0, 0,0,1,0,300};  // heart queued, no pulse
    vecs[12] = '{0,1,0,0,0, 0,0,1,0,299};  // tick
    vecs[13] = '{1,1,0,0,1, 0,0,1,0,299};  // paused: no tick, star ignored
    vecs[14] = '{0,0,0,0,1, 0,0,1,0,299};  // star held through pause: no edge
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].pause, vecs[i].tick, vecs[i].obs, vecs[i].heart, vecs[i].star);
      step();
      chk($sformatf("vec%0d_hurt", i), int'(bus.HURT), int'(vecs[i].hurt));
      chk($sformatf("vec%0d_rec", i),  int'(bus.RECOVER), int'(vecs[i].rec));
      chk($sformatf("vec%0d_en", i),   int'(bus.INVINCIBLE_ENABLE), int'(vecs[i].en));
      chk($sformatf("vec%0d_cd", i),   int'(bus.COOLDOWN_ACTIVE), int'(vecs[i].cd));
      chk($sformatf("vec%0d_left", i), int'(bus.INVINCIBLE_LEFT), int'(vecs[i].left));
    end

    // ---- 1: cooldown window of 60 ticks
    do_reset();
    bus.HIT_OBSTACLE = 1; step();
    chk("cd_hurt", int'(bus.HURT), 1);
    chk("cd_active", int'(bus.COOLDOWN_ACTIVE), 1);
    bus.HIT_OBSTACLE = 0; step();
    chk("cd_hurt_1cyc", int'(bus.HURT), 0);
    hurt_seen = 0; rec_seen = 0;
    frames(29);
    bus.FRAME_TICK = 1; bus.HIT_OBSTACLE = 1; step();   // tick 30 + obstacle
    chk("cd_t30_nohurt", int'(bus.HURT), 0);
    bus.FRAME_TICK = 0; bus.HIT_OBSTACLE = 0; step();
    chk("cd_t30_nohurt2", int'(bus.HURT), 0);
    frames(29);
    chk("cd_t59_active", int'(bus.COOLDOWN_ACTIVE), 1);
    chk("cd_no_hurt_window", hurt_seen, 0);
    bus.FRAME_TICK = 1; step();
    chk("cd_t60_done", int'(bus.COOLDOWN_ACTIVE), 0);
    bus.FRAME_TICK = 0; bus.HIT_OBSTACLE = 1; step();
    chk("cd_rehurt", int'(bus.HURT), 1);
    bus.HIT_OBSTACLE = 0; step();

    // ---- 6: pause freezes cooldown and discards edges
    do_reset();
    bus.HIT_OBSTACLE = 1; step(); bus.HIT_OBSTACLE = 0; step();
    frames(10);                         // 50 left
    hurt_seen = 0;
    bus.PAUSE = 1;
    frames(10);
    bus.HIT_OBSTACLE = 1; step();
    chk("pause_nohurt", int'(bus.HURT), 0);
    bus.HIT_OBSTACLE = 0; step();
    frames(10);
    chk("pause_cd_held", int'(bus.COOLDOWN_ACTIVE), 1);
    bus.PAUSE = 0;
    frames(49);
    chk("pause_cd_49", int'(bus.COOLDOWN_ACTIVE), 1);
    chk("pause_hurt_seen", hurt_seen, 0);
    frames(1);
    chk("pause_cd_50", int'(bus.COOLDOWN_ACTIVE), 0);

    // ---- 2: star window and reload
    do_reset();
    bus.HIT_STAR = 1; step();
    chk("inv_en", int'(bus.INVINCIBLE_ENABLE), 1);
    chk("inv_left300", int'(bus.INVINCIBLE_LEFT), 300);
    bus.HIT_STAR = 0; step();
    frames(200);
    chk("inv_left100", int'(bus.INVINCIBLE_LEFT), 100);
    bus.HIT_STAR = 1; step();
    chk("inv_reload", int'(bus.INVINCIBLE_LEFT), 300);
    bus.HIT_STAR = 0; step();
    frames(299);
    chk("inv_299_en", int'(bus.INVINCIBLE_ENABLE), 1);
    chk("inv_299_left", int'(bus.INVINCIBLE_LEFT), 1);
    frames(1);
    chk("inv_300_en", int'(bus.INVINCIBLE_ENABLE), 0);
    chk("inv_300_left", int'(bus.INVINCIBLE_LEFT), 0);
    chk("inv_300_cd", int'(bus.COOLDOWN_ACTIVE), 1);

    // ---- 3: queued hearts replay after the window
    do_reset();
    bus.HIT_STAR = 1; step(); bus.HIT_STAR = 0; step();
    rec_seen = 0;
    for (int i = 0; i < 3; i++) begin
      bus.HIT_HEART = 1; step(); rec_seen += int'(bus.RECOVER);
      bus.HIT_HEART = 0; step(); rec_seen += int'(bus.RECOVER);
    end
    frames(299);
    chk("q_no_rec_window", rec_seen, 0);
    bus.FRAME_TICK = 1; step();                  // expiry edge T
    chk("q_T_en", int'(bus.INVINCIBLE_ENABLE), 0);
    chk("q_T_rec", int'(bus.RECOVER), 0);
    bus.FRAME_TICK = 0; step();
    chk("q_T1_rec", int'(bus.RECOVER), 1);
    chk("q_T1_cd", int'(bus.COOLDOWN_ACTIVE), 0);
    step();
    chk("q_T2_rec", int'(bus.RECOVER), 1);
    chk("q_T2_cd", int'(bus.COOLDOWN_ACTIVE), 1);
    step();
    chk("q_T3_rec", int'(bus.RECOVER), 0);
    chk("q_T3_cd", int'(bus.COOLDOWN_ACTIVE), 1);

    // ---- 4: simultaneous events
    do_reset();
    drive(0, 0, 1, 1, 1); step();
    chk("sim3_hurt", int'(bus.HURT), 0);
    chk("sim3_rec", int'(bus.RECOVER), 1);
    chk("sim3_en", int'(bus.INVINCIBLE_ENABLE), 1);
    drive(0, 0, 0, 0, 0); step();
    do_reset();
    drive(0, 0, 1, 1, 0); step();
    chk("sim2_hurt", int'(bus.HURT), 0);
    chk("sim2_rec", int'(bus.RECOVER), 0);
    chk("sim2_cd", int'(bus.COOLDOWN_ACTIVE), 1);
    drive(0, 0, 0, 0, 0); step();

    // ---- 5: reset corner cases
    RESET = 1; bus.HIT_OBSTACLE = 1; step(); step();
    RESET = 0; step();
    chk("rst_held_hurt", int'(bus.HURT), 0);
    step();
    chk("rst_held_hurt2", int'(bus.HURT), 0);
    chk("rst_held_cd", int'(bus.COOLDOWN_ACTIVE), 0);
    bus.HIT_OBSTACLE = 0; step();
    bus.HIT_STAR = 1; step(); bus.HIT_STAR = 0; step();
    frames(150);
    chk("rst_mid_left150", int'(bus.INVINCIBLE_LEFT), 150);
    RESET = 1; step();
    chk("rst_mid_en", int'(bus.INVINCIBLE_ENABLE), 0);
    chk("rst_mid_left", int'(bus.INVINCIBLE_LEFT), 0);
    RESET = 0; step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
